bfly_scheduler: RTL and testbench

BFLY_SCHEDULER -- requirements
Module: bfly_scheduler

---
 rtl/bfly_scheduler.sv | 130 +++++++++++++
 tb/tb_bfly_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bfly_scheduler.sv
// Round-robin scheduler sharing one fixed-latency butterfly unit among
// four requesters; tags follow each operation so results come back in order.
module bfly_scheduler #(
  parameter int N = 4,
  parameter int LAT = 3,
  localparam int W = 2 ** N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] req_a,
  input  logic [4*W-1:0] req_b,
  output logic [3:0]     gnt,
  output logic [W-1:0]   bf_in_1,
  output logic [W-1:0]   bf_in_2,
  input  logic [W-1:0]   bf_out_real,
  input  logic [W-1:0]   bf_out_image,
  output logic           res_valid,
  output logic [1:0]     res_id,
  output logic [W-1:0]   res_real,
  output logic [W-1:0]   res_image,
  output logic           idle
);

  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   gid, idx;
  logic         hit, take;
  logic [LAT-1:0] tv_q;
  logic [1:0]   tid_q [LAT];
  logic [3:0]   cnt_q, cnt_d;
  logic         done;
  logic         rv_q;
  logic [1:0]   rid_q;
  logic [W-1:0] rre_q, rim_q;

  // Lowest offset from ptr wins, so scan high to low and overwrite.
  always_comb begin
    hit = 1'b0;
    gid = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        hit = 1'b1;
        gid = idx;
      end
    end
  end

  assign take = hit && en && !rst;
  assign gnt  = take ? (4'b0001 << gid) : 4'b0000;
  assign ptr_d = take ? gid + 2'd1 : ptr_q;

  always_comb begin
    bf_in_1 = '0;
    bf_in_2 = '0;
    unique case (1'b1)
      gnt[0]: begin
        bf_in_1 = req_a[0*W +: W];
        bf_in_2 = req_b[0*W +: W];
      end
      gnt[1]: begin
        bf_in_1 = req_a[1*W +: W];
        bf_in_2 = req_b[1*W +: W];
      end
      gnt[2]: begin
        bf_in_1 = req_a[2*W +: W];
        bf_in_2 = req_b[2*W +: W];
      end
      gnt[3]: begin
        bf_in_1 = req_a[3*W +: W];
        bf_in_2 = req_b[3*W +: W];
      end
      default: ;
    endcase
  end

  assign done = tv_q[LAT-1];

  always_comb begin
    cnt_d = cnt_q;
    if (take && !done)
      cnt_d = cnt_q + 4'd1;
    else if (!take && done)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
      cnt_q <= 4'd0;
      tv_q  <= '0;
      for (int i = 0; i < LAT; i++)
        tid_q[i] <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tv_q[0]  <= take;
      tid_q[0] <= take ? gid : 2'd0;
      for (int i = 1; i < LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q  <= 1'b0;
      rid_q <= 2'd0;
      rre_q <= '0;
      rim_q <= '0;
    end else begin
      rv_q <= done;
      if (done) begin
        rid_q <= tid_q[LAT-1];
        rre_q <= bf_out_real;
        rim_q <= bf_out_image;
      end
    end
  end

  assign res_valid = rv_q;
  assign res_id    = rid_q;
  assign res_real  = rre_q;
  assign res_image = rim_q;
  assign idle      = (cnt_q == 4'd0) && (gnt == 4'b0000);

endmodule

// File: tb/tb_bfly_scheduler.sv
// Directed bench for bfly_scheduler: LAT=3 main instance plus a LAT=1
// instance; butterfly stubs echo operands after LAT cycles.
module tb_bfly_scheduler;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [3:0]    req = 4'b0;
  logic [4*W-1:0] req_a = '0;
  logic [4*W-1:0] req_b = '0;

  logic [3:0]   gnt0, gnt1;
  logic [W-1:0] bi1_0, bi2_0, bi1_1, bi2_1;
  logic [W-1:0] bor0, boi0, bor1, boi1;
  logic         rv0, rv1, idle0, idle1;
  logic [1:0]   rid0, rid1;
  logic [W-1:0] rre0, rim0, rre1, rim1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bfly_scheduler #(.N(4), .LAT(3)) u0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .req_a(req_a), .req_b(req_b), .gnt(gnt0),
    .bf_in_1(bi1_0), .bf_in_2(bi2_0),
    .bf_out_real(bor0), .bf_out_image(boi0),
    .res_valid(rv0), .res_id(rid0),
    .res_real(rre0), .res_image(rim0), .idle(idle0)
  );

  bfly_scheduler #(.N(4), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .req_a(req_a), .req_b(req_b), .gnt(gnt1),
    .bf_in_1(bi1_1), .bf_in_2(bi2_1),
    .bf_out_real(bor1), .bf_out_image(boi1),
    .res_valid(rv1), .res_id(rid1),
    .res_real(rre1), .res_image(rim1), .idle(idle1)
  );

  logic [2*W-1:0] p0 [3];
  logic [2*W-1:0] p1;

  always @(posedge clk) begin
    p0[0] <= {bi1_0, bi2_0};
    p0[1] <= p0[0];
    p0[2] <= p0[1];
    p1    <= {bi1_1, bi2_1};
  end

  assign bor0 = p0[2][2*W-1:W];
  assign boi0 = p0[2][W-1:0];
  assign bor1 = p1[2*W-1:W];
  assign boi1 = p1[W-1:0];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] q;
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    logic       idl;
  } vec_t;

  vec_t tbl [26];

  function automatic logic [W-1:0] opa(input logic [3:0] g);
    logic [W-1:0] x = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) x = 16'(16'h1100 * (i + 1));
    return x;
  endfunction

  function automatic logic [W-1:0] opb(input logic [3:0] g);
    logic [W-1:0] x = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) x = 16'(16'h0011 * (i + 1));
    return x;
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 4'h4, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'h8, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 4'h4, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 4'h8, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd3, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 2'd3, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'hB, 4'h8, 1'b0, 2'd3, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'hB, 4'h1, 1'b0, 2'd3, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'hB, 4'h2, 1'b0, 2'd3, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 4'hB, 4'h8, 1'b1, 2'd1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b1, 2'd3, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 4'hF, 4'h2, 1'b1, 2'd0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 2'd3, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 2'd1, 1'b1};
    tbl[25] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd1, 1'b1};

    req_a = {16'h4400, 16'h3300, 16'h2200, 16'h1100};
    req_b = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].q);
      chk($sformatf("gnt[%0d]", i), 32'(gnt0), 32'(tbl[i].g));
      chk($sformatf("bf1[%0d]", i), 32'(bi1_0), 32'(opa(tbl[i].g)));
      chk($sformatf("bf2[%0d]", i), 32'(bi2_0), 32'(opb(tbl[i].g)));
      chk($sformatf("rv[%0d]", i), 32'(rv0), 32'(tbl[i].v));
      chk($sformatf("rid[%0d]", i), 32'(rid0), 32'(tbl[i].id));
      chk($sformatf("idle[%0d]", i), 32'(idle0), 32'(tbl[i].idl));
      if (tbl[i].v) begin
        chk($sformatf("rre[%0d]", i), 32'(rre0),
            32'(16'(16'h1100 * (tbl[i].id + 1))));
        chk($sformatf("rim[%0d]", i), 32'(rim0),
            32'(16'(16'h0011 * (tbl[i].id + 1))));
      end
    end

    // Single transaction with data check, both latencies.
    req_a[15:0] = 16'h1234;
    req_b[15:0] = 16'h00FF;
    step(1'b0, 1'b1, 4'b0001);
    chk("single_gnt", 32'(gnt0), 32'h1);
    chk("single_gnt_l1", 32'(gnt1), 32'h1);
    chk("single_bf1", 32'(bi1_0), 32'h1234);
    chk("single_bf2", 32'(bi2_0), 32'h00FF);
    step(1'b0, 1'b1, 4'b0000);
    chk("single_rv_g1", 32'(rv0), 32'h0);
    chk("l1_rv_g1", 32'(rv1), 32'h0);
    step(1'b0, 1'b1, 4'b0000);
    chk("single_rv_g2", 32'(rv0), 32'h0);
    chk("l1_rv_g2", 32'(rv1), 32'h1);
    chk("l1_rre", 32'(rre1), 32'h1234);
    chk("l1_rim", 32'(rim1), 32'h00FF);
    chk("l1_idle", 32'(idle1), 32'h1);
    step(1'b0, 1'b1, 4'b0000);
    chk("single_rv_g3", 32'(rv0), 32'h0);
    chk("l1_rv_g3", 32'(rv1), 32'h0);
    step(1'b0, 1'b1, 4'b0000);
    chk("single_rv_g4", 32'(rv0), 32'h1);
    chk("single_rid", 32'(rid0), 32'h0);
    chk("single_rre", 32'(rre0), 32'h1234);
    chk("single_rim", 32'(rim0), 32'h00FF);
    step(1'b0, 1'b1, 4'b0000);
    chk("single_rv_g5", 32'(rv0), 32'h0);
    chk("single_idle", 32'(idle0), 32'h1);

    // Reset in flight discards the tag.
    step(1'b0, 1'b1, 4'b0010);
    chk("pre_rst_gnt", 32'(gnt0), 32'h2);
    step(1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 4'b1111);
      chk("rst_gnt", 32'(gnt0), 32'h0);
      chk("rst_bf1", 32'(bi1_0), 32'h0);
      chk("rst_bf2", 32'(bi2_0), 32'h0);
      chk("rst_rv", 32'(rv0), 32'h0);
      chk("rst_rid", 32'(rid0), 32'h0);
      chk("rst_rre", 32'(rre0), 32'h0);
      chk("rst_rim", 32'(rim0), 32'h0);
      chk("rst_idle", 32'(idle0), 32'h1);
    end
    step(1'b0, 1'b1, 4'b0100);
    chk("post_rst_gnt", 32'(gnt0), 32'h4);
    chk("post_rst_rv0", 32'(rv0), 32'h0);
    for (int c = 1; c < 4; c++) begin
      step(1'b0, 1'b1, 4'b0000);
      chk($sformatf("post_rst_rv%0d", c), 32'(rv0), 32'h0);
    end
    step(1'b0, 1'b1, 4'b0000);
    chk("post_rst_res_rv", 32'(rv0), 32'h1);
    chk("post_rst_res_id", 32'(rid0), 32'h2);
    chk("post_rst_res_re", 32'(rre0), 32'h3300);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
